// File: rtl/ifm.sv
// Instruction fetch stage: fetches one word at a time over a pipelined Wishbone master
// and presents {pc, instr} pairs downstream. Branch redirects flush any in-flight fetch.
module ifm #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        branch_i,
    input  logic [19:0] branch_offset_i,
    input  logic [31:0] branch_pc_i,
    output logic [31:0] wb_adr_o,
    input  logic [31:0] wb_dat_i,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic        wb_ack_i,
    input  logic        wb_stall_i,
    input  logic        output_ready_i,
    output logic        output_valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o
);

    typedef enum logic [1:0] {
        REQUEST  = 2'd0,
        WAIT_ACK = 2'd1,
        HOLD     = 2'd2
    } state_t;

    state_t      state_reg,   state_next;
    logic [31:0] pc_reg,      pc_next;
    logic        discard_reg, discard_next;
    logic [31:0] adr_reg,     adr_next;
    logic        stb_reg,     stb_next;
    logic        cyc_reg,     cyc_next;
    logic        valid_reg,   valid_next;
    logic [31:0] pc_out_reg,  pc_out_next;
    logic [31:0] instr_reg,   instr_next;

    logic [31:0] target;
    logic [31:0] target_raw;
    logic        accepted;

    // Halfword offset scaled to bytes; instructions are word aligned so the low bits are cleared.
    assign target_raw = branch_pc_i + {{11{branch_offset_i[19]}}, branch_offset_i, 1'b0};
    assign target     = {target_raw[31:2], 2'b00};
    assign accepted   = stb_reg && !wb_stall_i;

    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        discard_next = discard_reg;
        adr_next     = adr_reg;
        stb_next     = stb_reg;
        cyc_next     = cyc_reg;
        valid_next   = valid_reg;
        pc_out_next  = pc_out_reg;
        instr_next   = instr_reg;

        unique case (state_reg)
            REQUEST: begin
                // stb_reg is low only in the first cycle after reset; raise it then.
                cyc_next = 1'b1;
                if (accepted) begin
                    state_next = WAIT_ACK;
                    stb_next   = 1'b0;
                    if (branch_i) begin
                        pc_next      = target;
                        discard_next = 1'b1;
                    end
                end else begin
                    stb_next = 1'b1;
                    if (branch_i) begin
                        pc_next  = target;
                        adr_next = target;
                    end else begin
                        adr_next = pc_reg;
                    end
                end
            end
            WAIT_ACK: begin
                if (wb_ack_i) begin
                    if (branch_i || discard_reg) begin
                        state_next   = REQUEST;
                        discard_next = 1'b0;
                        stb_next     = 1'b1;
                        cyc_next     = 1'b1;
                        pc_next      = branch_i ? target : pc_reg;
                        adr_next     = branch_i ? target : pc_reg;
                    end else begin
                        state_next  = HOLD;
                        cyc_next    = 1'b0;
                        valid_next  = 1'b1;
                        pc_out_next = pc_reg;
                        instr_next  = wb_dat_i;
                    end
                end else if (branch_i) begin
                    pc_next      = target;
                    discard_next = 1'b1;
                end
            end
            HOLD: begin
                // A redirect takes priority over a same-cycle handshake.
                if (branch_i || output_ready_i) begin
                    state_next = REQUEST;
                    valid_next = 1'b0;
                    stb_next   = 1'b1;
                    cyc_next   = 1'b1;
                    pc_next    = branch_i ? target : pc_reg + 32'd4;
                    adr_next   = branch_i ? target : pc_reg + 32'd4;
                end
            end
            default: begin
                state_next = REQUEST;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg   <= REQUEST;
            pc_reg      <= RESET_ADDR;
            discard_reg <= 1'b0;
            adr_reg     <= 32'd0;
            stb_reg     <= 1'b0;
            cyc_reg     <= 1'b0;
            valid_reg   <= 1'b0;
            pc_out_reg  <= 32'd0;
            instr_reg   <= 32'd0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            discard_reg <= discard_next;
            adr_reg     <= adr_next;
            stb_reg     <= stb_next;
            cyc_reg     <= cyc_next;
            valid_reg   <= valid_next;
            pc_out_reg  <= pc_out_next;
            instr_reg   <= instr_next;
        end
    end

    assign wb_adr_o       = adr_reg;
    assign wb_sel_o       = 4'hF;
    assign wb_we_o        = 1'b0;
    assign wb_stb_o       = stb_reg;
    assign wb_cyc_o       = cyc_reg;
    assign output_valid_o = valid_reg;
    assign pc_o           = pc_out_reg;
    assign instr_o        = instr_reg;

endmodule

// File: tb/tb_ifm.sv
// Directed bench for ifm: bus timing, backpressure, stalls, redirects, reset and PC wrap.
module tb_ifm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        branch = 1'b0;
    logic [19:0] branch_offset = 20'd0;
    logic [31:0] branch_pc = 32'd0;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat = 32'd0;
    logic [3:0]  wb_sel;
    logic        wb_we;
    logic        wb_stb;
    logic        wb_cyc;
    logic        wb_ack = 1'b0;
    logic        wb_stall = 1'b0;
    logic        ready = 1'b0;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;

    int n_tests = 0;
    int n_fail  = 0;

    ifm #(.RESET_ADDR(32'h0000_0000)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .branch_i        (branch),
        .branch_offset_i (branch_offset),
        .branch_pc_i     (branch_pc),
        .wb_adr_o        (wb_adr),
        .wb_dat_i        (wb_dat),
        .wb_sel_o        (wb_sel),
        .wb_we_o         (wb_we),
        .wb_stb_o        (wb_stb),
        .wb_cyc_o        (wb_cyc),
        .wb_ack_i        (wb_ack),
        .wb_stall_i      (wb_stall),
        .output_ready_i  (ready),
        .output_valid_o  (valid),
        .pc_o            (pc),
        .instr_o         (instr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expects a request for adr on the bus right now; zero-wait slave answers with data.
    task automatic fetch(input string tag, input logic [31:0] adr, input logic [31:0] data);
        chk({tag, "_stb"}, {31'd0, wb_stb}, 32'd1);
        chk({tag, "_adr"}, wb_adr, adr);
        tick();
        chk({tag, "_stb_drop"}, {31'd0, wb_stb}, 32'd0);
        wb_ack = 1'b1;
        wb_dat = data;
        tick();
        wb_ack = 1'b0;
        chk({tag, "_valid"}, {31'd0, valid}, 32'd1);
        chk({tag, "_pc"}, pc, adr);
        chk({tag, "_instr"}, instr, data);
        chk({tag, "_cyc_drop"}, {31'd0, wb_cyc}, 32'd0);
    endtask

    task automatic handshake();
        ready = 1'b1;
        tick();
        ready = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_stb", {31'd0, wb_stb}, 32'd0);
        chk("rst_cyc", {31'd0, wb_cyc}, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_sel", {28'd0, wb_sel}, 32'hF);
        chk("rst_we", {31'd0, wb_we}, 32'd0);
        rst = 1'b0;
        tick();
        chk("first_cyc", {31'd0, wb_cyc}, 32'd1);

        // 1: sequential fetches
        fetch("seq0", 32'h0, 32'h0000_0013);
        handshake();
        chk("seq1_valid_drop", {31'd0, valid}, 32'd0);
        fetch("seq1", 32'h4, 32'h0000_0013);

        // 2: downstream backpressure for 5 cycles
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", {31'd0, valid}, 32'd1);
            chk("bp_pc", pc, 32'h4);
            chk("bp_instr", instr, 32'h0000_0013);
            chk("bp_no_stb", {31'd0, wb_stb}, 32'd0);
        end
        handshake();
        fetch("seq2", 32'h8, 32'hAABB_CCDD);
        handshake();

        // 3: slave stalls for 3 cycles
        chk("stall_adr0", wb_adr, 32'hC);
        wb_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_stb", {31'd0, wb_stb}, 32'd1);
            chk("stall_adr", wb_adr, 32'hC);
        end
        wb_stall = 1'b0;
        fetch("stall_done", 32'hC, 32'h0000_0055);
        wb_ack = 1'b1;
        wb_dat = 32'hDEAD_BEEF;
        tick();
        wb_ack = 1'b0;
        chk("stray_ack_instr", instr, 32'h0000_0055);
        chk("stray_ack_valid", {31'd0, valid}, 32'd1);
        handshake();

        // 4: branch while waiting for ack -> returning data dropped
        chk("br_wait_adr0", wb_adr, 32'h10);
        tick();
        branch = 1'b1;
        branch_pc = 32'h100;
        branch_offset = 20'h00010;
        tick();
        branch = 1'b0;
        chk("br_wait_stb", {31'd0, wb_stb}, 32'd0);
        wb_ack = 1'b1;
        wb_dat = 32'h0000_0BAD;
        tick();
        wb_ack = 1'b0;
        chk("br_wait_drop_valid", {31'd0, valid}, 32'd0);
        fetch("br_wait", 32'h120, 32'h0000_0077);

        // 5: branch beats same-cycle handshake
        branch = 1'b1;
        branch_pc = 32'h40;
        branch_offset = 20'hFFFF8;
        ready = 1'b1;
        tick();
        branch = 1'b0;
        ready = 1'b0;
        chk("br_hold_valid", {31'd0, valid}, 32'd0);
        chk("br_hold_adr", wb_adr, 32'h30);
        chk("br_hold_stb", {31'd0, wb_stb}, 32'd1);

        // Branch in REQUEST while stalled: address switches, no discard
        wb_stall = 1'b1;
        branch = 1'b1;
        branch_pc = 32'h200;
        branch_offset = 20'h00008;
        tick();
        branch = 1'b0;
        wb_stall = 1'b0;
        fetch("br_stall", 32'h210, 32'h0000_0099);
        handshake();
        chk("br_stall_next", wb_adr, 32'h214);

        // Branch in the same cycle as ack
        tick();
        branch = 1'b1;
        branch_pc = 32'h300;
        branch_offset = 20'h00000;
        wb_ack = 1'b1;
        wb_dat = 32'h0000_0111;
        tick();
        branch = 1'b0;
        wb_ack = 1'b0;
        chk("br_ack_valid", {31'd0, valid}, 32'd0);
        fetch("br_ack", 32'h300, 32'h0000_0222);
        handshake();

        // 6: reset during WAIT_ACK, late ack ignored
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_stb", {31'd0, wb_stb}, 32'd0);
        chk("rst_mid_cyc", {31'd0, wb_cyc}, 32'd0);
        wb_ack = 1'b1;
        wb_dat = 32'h0000_0333;
        tick();
        wb_ack = 1'b0;
        chk("rst_mid_valid", {31'd0, valid}, 32'd0);
        fetch("rst_mid", 32'h0, 32'h0000_0013);

        // Odd halfword offset: target low bits cleared
        branch = 1'b1;
        branch_pc = 32'h500;
        branch_offset = 20'h00001;
        tick();
        branch = 1'b0;
        chk("align_adr", wb_adr, 32'h500);
        fetch("align", 32'h500, 32'h0000_0444);

        // PC wrap FFFF_FFFC -> 0
        branch = 1'b1;
        branch_pc = 32'hFFFF_FFF0;
        branch_offset = 20'h00006;
        tick();
        branch = 1'b0;
        fetch("wrap", 32'hFFFF_FFFC, 32'h0000_0555);
        handshake();
        chk("wrap_adr", wb_adr, 32'h0);
        chk("wrap_stb", {31'd0, wb_stb}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
